inst_fetch_bridge: RTL

- Sits between the CPU core's instruction port (rom_addr / rom_ce / rom_inst) and a byte-wide synchronous instruction memory.
- Assembles 32-bit little-endian instructions from four sequential byte reads.
- Holds a one-entry instruction buffer (tag plus word) so a repeated PC, e.g. during a pipeline stall, returns without a memory access.
- Drives stallreq_if into ctrl while a fetch is in flight.

---
 rtl/inst_fetch_bridge.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_bridge
//  Purpose  : Bridges the core's 32-bit instruction port to a byte-wide
//             synchronous instruction memory. A miss issues four sequential
//             byte reads and assembles a little-endian word. A one-entry
//             buffer (tag + word) serves repeated PCs without a memory
//             access. stallreq_if holds the pipeline while a fetch is pending.
//  Ports    : clk          - clock, rising edge
//             rst          - asynchronous reset, active low
//             pc_i         - instruction address (byte address)
//             ce_i         - fetch enable
//             invalidate_i - clears the buffer tag at the next edge
//             inst_o       - instruction word, zero when not a serviced hit
//             stallreq_if  - stall request while the instruction is not ready
//             mem_addr     - byte address to instruction memory
//             mem_re       - memory read enable
//             mem_rdata    - read data, valid one cycle after mem_addr/mem_re
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     pc_i,
    input  logic                      ce_i,
    input  logic                      invalidate_i,
    output logic [31:0]               inst_o,
    output logic                      stallreq_if,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      mem_re,
    input  logic [7:0]                mem_rdata
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // cnt value of the final BUSY cycle: the fourth byte lands, no new read
    localparam logic [2:0] c_LAST_CNT = 3'd4;

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   req_pc_q, req_pc_d;
    logic [ADDR_WIDTH-3:0]   tag_q, tag_d;
    logic                    tag_valid_q, tag_valid_d;
    logic [31:0]             word_q, word_d;

    logic                      w_hit;
    logic                      w_idle_hit;
    logic [MEM_ADDR_WIDTH-1:0] w_addr_sum;
    logic                      w_unused_pc_lsbs;

    // Byte offset within the word carries no information for the fetch
    assign w_unused_pc_lsbs = ^pc_i[1:0];

    assign w_hit      = tag_valid_q && (tag_q == pc_i[ADDR_WIDTH-1:2]);
    assign w_idle_hit = (state_q == ST_IDLE) && w_hit;

    // Only the low bits matter, so the sum wraps at the memory size
    assign w_addr_sum = req_pc_q[MEM_ADDR_WIDTH-1:0] + MEM_ADDR_WIDTH'(cnt_q);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_re      = (state_q == ST_BUSY) && (cnt_q < c_LAST_CNT);
        mem_addr    = mem_re ? w_addr_sum : '0;
        stallreq_if = ce_i && !w_idle_hit;
        inst_o      = (w_idle_hit && ce_i) ? word_q : 32'h0;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_pc_d    = req_pc_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        word_d      = word_q;

        case (state_q)
            ST_IDLE: begin
                if (ce_i && !w_hit) begin
                    state_d  = ST_BUSY;
                    cnt_d    = 3'd0;
                    req_pc_d = {pc_i[ADDR_WIDTH-1:2], 2'b00};
                end
            end
            ST_BUSY: begin
                // Data for the read issued at cnt-1 arrives while at cnt
                case (cnt_q)
                    3'd1:    word_d[7:0]   = mem_rdata;
                    3'd2:    word_d[15:8]  = mem_rdata;
                    3'd3:    word_d[23:16] = mem_rdata;
                    3'd4:    word_d[31:24] = mem_rdata;
                    default: word_d        = word_q;
                endcase

                // The fetch always runs to completion, even if pc_i or ce_i
                // change meanwhile; a new PC simply misses afterwards.
                if (cnt_q < c_LAST_CNT) begin
                    cnt_d = cnt_q + 3'd1;
                end else begin
                    state_d     = ST_IDLE;
                    tag_d       = req_pc_q[ADDR_WIDTH-1:2];
                    tag_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Invalidate overrides a fill completing on the same edge
        if (invalidate_i) begin
            tag_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            req_pc_q    <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            word_q      <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_pc_q    <= req_pc_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            word_q      <= word_d;
        end
    end

endmodule
`default_nettype wire
